// File: rtl/spi_slave_pkg.sv
// Shared encodings for the SPI frame slave: command codes and FSM state enum.
package spi_slave_pkg;

    typedef enum logic [1:0] {
        CMD_WR_ADDR = 2'b00,
        CMD_WR_DATA = 2'b01,
        CMD_RD_ADDR = 2'b10,
        CMD_RD_DATA = 2'b11
    } cmd_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_SHIFT,
        ST_WAIT_TX,
        ST_TX,
        ST_HOLD
    } state_e;

endpackage

// File: rtl/spi_slave_param.sv
// Clk-sampled SPI frame slave: {cmd[1:0], payload} in on mosi, RAM read data out on miso.
// state      | meaning
// ST_IDLE    | waiting for ss_n low
// ST_CMD     | sampling cmd[1] then cmd[0]
// ST_SHIFT   | sampling PAY_W payload bits
// ST_WAIT_TX | read-data frame accepted, waiting for tx_valid or timeout
// ST_TX      | shifting latched tx data out on miso
// ST_HOLD    | frame finished, waiting for ss_n high
module spi_slave_param
    import spi_slave_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 8,
    parameter int TX_TIMEOUT  = 16,
    localparam int PAY_W      = (ADDR_W > DATA_W) ? ADDR_W : DATA_W,
    localparam int FRAME_W    = PAY_W + 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ss_n,
    input  logic               mosi,
    output logic               miso,
    output logic [FRAME_W-1:0] rx_data,
    output logic               rx_valid,
    input  logic [DATA_W-1:0]  tx_data,
    input  logic               tx_valid,
    output logic               err
);

    // The bit counter also paces TX, which is always shorter than a frame.
    localparam int CNT_W = $clog2(FRAME_W);
    localparam int TMR_W = $clog2(TX_TIMEOUT + 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [TMR_W-1:0]   tmr_q, tmr_d;
    logic [FRAME_W-2:0] sh_q, sh_d;
    logic [DATA_W-1:0]  tx_sh_q, tx_sh_d;
    logic [FRAME_W-1:0] rx_data_q, rx_data_d;
    logic               rd_seen_q, rd_seen_d;
    logic               rx_valid_q, rx_valid_d;
    logic               err_q, err_d;
    logic               miso_q, miso_d;
    logic [FRAME_W-1:0] frame;
    logic [1:0]         cmd;
    logic               abort;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        tmr_d      = tmr_q;
        sh_d       = sh_q;
        tx_sh_d    = tx_sh_q;
        rx_data_d  = rx_data_q;
        rd_seen_d  = rd_seen_q;
        rx_valid_d = 1'b0;
        err_d      = 1'b0;
        miso_d     = 1'b0;
        frame      = {sh_q, mosi};
        cmd        = frame[FRAME_W-1 -: 2];
        abort      = ss_n && (state_q inside {ST_CMD, ST_SHIFT, ST_WAIT_TX, ST_TX});

        if (abort) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            tmr_d   = '0;
            err_d   = 1'b1;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (!ss_n) begin
                        state_d = ST_CMD;
                        cnt_d   = '0;
                    end
                end
                ST_CMD, ST_SHIFT: begin
                    sh_d = frame[FRAME_W-2:0];
                    if (cnt_q == CNT_W'(FRAME_W - 1)) begin
                        cnt_d   = '0;
                        state_d = ST_HOLD;
                        if (cmd == CMD_RD_DATA && !rd_seen_q) begin
                            err_d = 1'b1;
                        end else begin
                            rx_valid_d = 1'b1;
                            rx_data_d  = frame;
                            rd_seen_d  = (cmd == CMD_RD_ADDR);
                            if (cmd == CMD_RD_DATA) begin
                                state_d = ST_WAIT_TX;
                                tmr_d   = TMR_W'(TX_TIMEOUT - 1);
                            end
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                        if (state_q == ST_CMD && cnt_q == CNT_W'(1)) begin
                            state_d = ST_SHIFT;
                        end
                    end
                end
                ST_WAIT_TX: begin
                    if (tx_valid) begin
                        tx_sh_d = tx_data;
                        cnt_d   = '0;
                        state_d = ST_TX;
                    end else if (tmr_q == '0) begin
                        err_d   = 1'b1;
                        state_d = ST_HOLD;
                    end else begin
                        tmr_d = tmr_q - 1'b1;
                    end
                end
                ST_TX: begin
                    // One idle entry cycle, then DATA_W bits; the last bit stays up until HOLD.
                    if (cnt_q == CNT_W'(DATA_W)) begin
                        cnt_d   = '0;
                        state_d = ST_HOLD;
                    end else begin
                        miso_d  = tx_sh_q[DATA_W-1];
                        tx_sh_d = tx_sh_q << 1;
                        cnt_d   = cnt_q + 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (ss_n) begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            tmr_q      <= '0;
            sh_q       <= '0;
            tx_sh_q    <= '0;
            rx_data_q  <= '0;
            rd_seen_q  <= 1'b0;
            rx_valid_q <= 1'b0;
            err_q      <= 1'b0;
            miso_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            tmr_q      <= tmr_d;
            sh_q       <= sh_d;
            tx_sh_q    <= tx_sh_d;
            rx_data_q  <= rx_data_d;
            rd_seen_q  <= rd_seen_d;
            rx_valid_q <= rx_valid_d;
            err_q      <= err_d;
            miso_q     <= miso_d;
        end
    end

    assign miso     = miso_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign err      = err_q;

endmodule

// File: tb/tb_spi_slave_param.sv
// Bench for spi_slave_param: frame-level expectation timeline plus directed literal checks.
module tb_spi_slave_param;

    localparam int ADDR_W     = 8;
    localparam int DATA_W     = 8;
    localparam int TX_TIMEOUT = 16;
    localparam int PAY_W      = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
    localparam int FRAME_W    = PAY_W + 2;
    localparam int MAXC       = 20000;

    logic               clk = 1'b0;
    logic               rst;
    logic               ss_n;
    logic               mosi;
    logic               miso;
    logic [FRAME_W-1:0] rx_data;
    logic               rx_valid;
    logic [DATA_W-1:0]  tx_data;
    logic               tx_valid;
    logic               err;

    int checks = 0;
    int passed = 0;
    int cyc    = 0;
    bit chk_en = 1'b0;
    bit done   = 1'b0;

    // Expected outputs per cycle, written ahead of time by the stimulus tasks.
    bit                 exp_rxv  [MAXC];
    bit                 exp_err  [MAXC];
    bit                 exp_miso [MAXC];
    bit                 rxd_set  [MAXC];
    logic [FRAME_W-1:0] rxd_val  [MAXC];
    logic [FRAME_W-1:0] cur_rxd = '0;
    bit                 model_seen = 1'b0;

    spi_slave_param #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TX_TIMEOUT(TX_TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst), .ss_n(ss_n), .mosi(mosi), .miso(miso),
        .rx_data(rx_data), .rx_valid(rx_valid), .tx_data(tx_data),
        .tx_valid(tx_valid), .err(err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
    endtask

    always @(negedge clk) begin
        if (chk_en && !done) begin
            if (rxd_set[cyc]) cur_rxd = rxd_val[cyc];
            check("rx_valid", 32'(rx_valid), 32'(exp_rxv[cyc]));
            check("err", 32'(err), 32'(exp_err[cyc]));
            check("miso", 32'(miso), 32'(exp_miso[cyc]));
            check("rx_data", 32'(rx_data), 32'(cur_rxd));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_gap(input int n);
        for (int i = 0; i < n; i++) begin
            ss_n = 1'b1; mosi = 1'($urandom);
            tx_valid = 1'($urandom); tx_data = DATA_W'($urandom);
            tick();
        end
    endtask

    task automatic hold_exit(input int extra);
        for (int i = 0; i < extra; i++) begin
            mosi = 1'($urandom); tx_valid = 1'($urandom); tx_data = DATA_W'($urandom);
            tick();
        end
        idle_gap(1 + int'($urandom_range(0, 1)));
    endtask

    // Outcome of a complete frame as seen in cycle c.
    task automatic predict(input logic [FRAME_W-1:0] f, input int c, output bit to_wait);
        to_wait = 1'b0;
        if (f[FRAME_W-1 -: 2] == 2'b11 && !model_seen) begin
            exp_err[c] = 1'b1;
        end else begin
            exp_rxv[c] = 1'b1;
            rxd_set[c] = 1'b1;
            rxd_val[c] = f;
            to_wait    = (f[FRAME_W-1 -: 2] == 2'b11);
            model_seen = (f[FRAME_W-1 -: 2] == 2'b10);
        end
    endtask

    // Starts with the DUT idle. abort_at = frame bit index at which ss_n rises instead.
    task automatic send_frame(input logic [1:0] cmd, input logic [PAY_W-1:0] pay,
                              input int abort_at, output int c, output bit to_wait,
                              output bit aborted);
        logic [FRAME_W-1:0] f;
        f = {cmd, pay};
        aborted = 1'b0;
        to_wait = 1'b0;
        ss_n = 1'b0; mosi = 1'($urandom);
        tx_valid = 1'($urandom); tx_data = DATA_W'($urandom);
        for (int i = 0; i < FRAME_W; i++) begin
            tick();
            if (i == abort_at) begin
                ss_n = 1'b1;
                exp_err[cyc + 1] = 1'b1;
                tick();
                c = cyc;
                aborted = 1'b1;
                return;
            end
            mosi = f[FRAME_W-1-i];
            tx_valid = 1'($urandom); tx_data = DATA_W'($urandom);
            if (i == FRAME_W - 1) predict(f, cyc + 1, to_wait);
        end
        tick();
        c = cyc;
    endtask

    // Called in the first WAIT_TX cycle. mode 0: respond after d cycles, 1: withhold, 2: abort at d.
    task automatic serve_read(input int mode, input int d, input logic [DATA_W-1:0] val,
                              input int abort_tx, output logic [DATA_W-1:0] got,
                              output logic err_to, output logic miso_any);
        int c0, t0, nb;
        c0 = cyc; got = '0; err_to = 1'b0; miso_any = 1'b0;
        if (mode == 1) begin
            exp_err[c0 + TX_TIMEOUT] = 1'b1;
            for (int i = 0; i < TX_TIMEOUT; i++) begin
                tx_valid = 1'b0; tx_data = DATA_W'($urandom);
                tick();
                miso_any = miso_any | miso;
            end
            err_to = err;
            hold_exit(int'($urandom_range(0, 2)));
            return;
        end
        for (int i = 0; i < d; i++) begin
            tx_valid = 1'b0; tx_data = DATA_W'($urandom);
            tick();
        end
        if (mode == 2) begin
            ss_n = 1'b1; tx_valid = 1'b1; tx_data = DATA_W'($urandom);
            exp_err[cyc + 1] = 1'b1;
            tick();
            return;
        end
        tx_valid = 1'b1; tx_data = val;
        t0 = cyc + 1;
        nb = (abort_tx < 0) ? DATA_W : abort_tx;
        for (int j = 0; j < nb; j++) exp_miso[t0 + 1 + j] = val[DATA_W-1-j];
        tick();
        tx_valid = 1'($urandom); tx_data = DATA_W'($urandom);
        if (abort_tx >= 0) begin
            for (int k = 0; k < abort_tx; k++) tick();
            ss_n = 1'b1;
            exp_err[cyc + 1] = 1'b1;
            tick();
            return;
        end
        for (int k = 1; k <= DATA_W + 1; k++) begin
            tick();
            if (k <= DATA_W) got = {got[DATA_W-2:0], miso};
        end
        hold_exit(int'($urandom_range(0, 2)));
    endtask

    task automatic apply_reset();
        rst = 1'b1; ss_n = 1'b1; tx_valid = 1'b0;
        rxd_set[cyc + 1] = 1'b1;
        rxd_val[cyc + 1] = '0;
        model_seen = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    int                c;
    bit                tw, ab;
    logic [DATA_W-1:0] got;
    logic              e_to, m_any;
    logic [1:0]        rcmd;
    int                mode, abort_at, abort_tx, r;

    initial begin
        #(MAXC * 10 + 5000);
        if (!done) begin
            $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
            $fatal(1);
        end
    end

    initial begin
        rst = 1'b1; ss_n = 1'b1; mosi = 1'b0; tx_valid = 1'b0; tx_data = '0;
        tick();
        chk_en = 1'b1;
        check("reset_rx_valid", 32'(rx_valid), 32'd0);
        check("reset_err", 32'(err), 32'd0);
        check("reset_miso", 32'(miso), 32'd0);
        check("reset_rx_data", 32'(rx_data), 32'd0);
        tick();
        rst = 1'b0;
        idle_gap(1);

        // Read-data frame with no preceding read-address frame.
        send_frame(2'b11, 8'h00, -1, c, tw, ab);
        check("rd_no_addr_err", 32'(err), 32'd1);
        check("rd_no_addr_rxv", 32'(rx_valid), 32'd0);
        hold_exit(1);

        // Write address 0x3C.
        send_frame(2'b00, 8'h3C, -1, c, tw, ab);
        check("wr_addr_rx_data", 32'(rx_data), 32'h03C);
        check("wr_addr_rx_valid", 32'(rx_valid), 32'd1);
        check("model_wr_addr", 32'(rxd_val[c]), 32'h03C);
        hold_exit(0);

        // Read sequence: address 0x5A, then read-data, RAM answers 0xA5.
        send_frame(2'b10, 8'h5A, -1, c, tw, ab);
        check("rd_addr_rx_data", 32'(rx_data), 32'h25A);
        check("model_rd_seen", 32'(model_seen), 32'd1);
        hold_exit(1);
        send_frame(2'b11, 8'h00, -1, c, tw, ab);
        check("rd_data_rx_data", 32'(rx_data), 32'h300);
        check("model_to_wait", 32'(tw), 32'd1);
        serve_read(0, 2, 8'hA5, -1, got, e_to, m_any);
        check("miso_a5", 32'(got), 32'hA5);

        // Abort after five payload bits, then a normal frame.
        send_frame(2'b01, 8'hFF, 7, c, tw, ab);
        check("abort_err", 32'(err), 32'd1);
        check("abort_rxv", 32'(rx_valid), 32'd0);
        send_frame(2'b01, 8'h96, -1, c, tw, ab);
        check("post_abort_rx_data", 32'(rx_data), 32'h196);
        hold_exit(0);

        // Read data withheld for the full timeout.
        send_frame(2'b10, 8'h11, -1, c, tw, ab);
        hold_exit(0);
        send_frame(2'b11, 8'h22, -1, c, tw, ab);
        serve_read(1, 0, '0, -1, got, e_to, m_any);
        check("timeout_err", 32'(e_to), 32'd1);
        check("timeout_miso", 32'(m_any), 32'd0);

        // tx_valid coinciding with ss_n high in WAIT_TX.
        send_frame(2'b10, 8'h33, -1, c, tw, ab);
        hold_exit(0);
        send_frame(2'b11, 8'h44, -1, c, tw, ab);
        serve_read(2, 3, '0, -1, got, e_to, m_any);

        // Reset on the third TX bit of 0xE5.
        send_frame(2'b10, 8'h77, -1, c, tw, ab);
        hold_exit(0);
        send_frame(2'b11, 8'h00, -1, c, tw, ab);
        tx_valid = 1'b1; tx_data = 8'hE5;
        for (int j = 0; j < 3; j++) exp_miso[cyc + 2 + j] = 1'b1;
        tick();
        tx_valid = 1'b0;
        tick(); tick(); tick();
        check("tx_third_bit", 32'(miso), 32'd1);
        apply_reset();
        check("rst_tx_miso", 32'(miso), 32'd0);
        check("rst_tx_rxv", 32'(rx_valid), 32'd0);
        check("rst_tx_err", 32'(err), 32'd0);
        check("rst_tx_rx_data", 32'(rx_data), 32'd0);
        send_frame(2'b00, 8'h81, -1, c, tw, ab);
        check("post_rst_rx_data", 32'(rx_data), 32'h081);
        hold_exit(0);

        // Reset clears a pending read address.
        send_frame(2'b10, 8'h55, -1, c, tw, ab);
        hold_exit(0);
        apply_reset();
        send_frame(2'b11, 8'h00, -1, c, tw, ab);
        check("rst_clears_seen", 32'(err), 32'd1);
        hold_exit(0);

        for (int t = 0; t < 250 && cyc < MAXC - 200; t++) begin
            rcmd = 2'($urandom);
            if (model_seen && $urandom_range(0, 2) != 0) rcmd = 2'b11;
            abort_at = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, FRAME_W - 1)) : -1;
            send_frame(rcmd, PAY_W'($urandom), abort_at, c, tw, ab);
            if (ab) continue;
            if (tw) begin
                r = int'($urandom_range(0, 9));
                mode = (r < 7) ? 0 : ((r < 9) ? 1 : 2);
                abort_tx = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, DATA_W)) : -1;
                serve_read(mode, int'($urandom_range(0, TX_TIMEOUT - 1)), DATA_W'($urandom),
                           abort_tx, got, e_to, m_any);
            end else begin
                hold_exit(int'($urandom_range(0, 2)));
            end
        end

        idle_gap(3);
        done = 1'b1;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
